// File: rtl/rifle_hit_detector.sv
// Rifle hit detector: follows the ball in the AY-3-8500 video and, after a trigger
// press, scans one frame for ball pixels inside the aim window to drive shot/hit pulses.
module rifle_hit_detector #(
    parameter int AIM_R      = 4,
    parameter int XW         = 9,
    parameter int YW         = 9,
    parameter int SHOT_LINES = 16
) (
    input  logic          clk_16M,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          vid_ball,
    input  logic [XW-1:0] aim_x,
    input  logic [YW-1:0] aim_y,
    input  logic          trigger,
    output logic          shot_out,
    output logic          hit_out,
    output logic          busy,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic          ball_vld
);

    localparam int LCW = $clog2(SHOT_LINES + 1);
    localparam logic signed [XW:0] AIM_RX = (XW + 1)'(AIM_R);
    localparam logic signed [YW:0] AIM_RY = (YW + 1)'(AIM_R);

    typedef enum logic [1:0] {IDLE, ARMED, SCAN, REPORT} state_t;

    function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
        return (&v) ? v : v + XW'(1);
    endfunction

    function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
        return (&v) ? v : v + YW'(1);
    endfunction

    // Differences carry one extra bit so a window near 0 clips instead of wrapping.
    function automatic logic in_window(input logic [XW-1:0] px, input logic [YW-1:0] py,
                                       input logic [XW-1:0] ax, input logic [YW-1:0] ay);
        logic signed [XW:0] dx;
        logic signed [YW:0] dy;
        dx = $signed({1'b0, px}) - $signed({1'b0, ax});
        dy = $signed({1'b0, py}) - $signed({1'b0, ay});
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (dx <= AIM_RX) && (dy <= AIM_RY);
    endfunction

    state_t          state_q;
    logic            hsync_q, vsync_q, trig_q;
    logic            hs_rise_q, vs_rise_q, tr_rise_q;
    logic [XW-1:0]   x_q, x_d, cand_x_q, cand_x_d, ball_x_q, ball_x_d;
    logic [YW-1:0]   y_q, y_d, cand_y_q, cand_y_d, ball_y_q, ball_y_d;
    logic            found_q, found_d, ball_vld_q, ball_vld_d;
    logic            hit_flag_q, shot_q, hit_q;
    logic [LCW-1:0]  lines_q, lines_dec;
    logic            pix, win;

    assign pix       = vid_ball & ce_pix;
    assign win       = in_window(x_q, y_q, aim_x, aim_y);
    assign lines_dec = lines_q - LCW'(1);

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        found_d    = found_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        ball_vld_d = ball_vld_q;
        if (vs_rise_q) begin
            x_d = '0;
            y_d = '0;
        end else if (hs_rise_q) begin
            x_d = '0;
            y_d = sat_inc_y(y_q);
        end else if (ce_pix) begin
            x_d = sat_inc_x(x_q);
        end
        if (vs_rise_q) begin
            ball_x_d   = cand_x_q;
            ball_y_d   = cand_y_q;
            ball_vld_d = found_q;
            found_d    = 1'b0;
        end
        // A ball pixel on the vsync-rise cycle is the first one of the new frame.
        if (pix && !found_d) begin
            cand_x_d = x_q;
            cand_y_d = y_q;
            found_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_16M) begin
        if (reset) begin
            state_q    <= IDLE;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            trig_q     <= 1'b0;
            hs_rise_q  <= 1'b0;
            vs_rise_q  <= 1'b0;
            tr_rise_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            found_q    <= 1'b0;
            ball_x_q   <= '0;
            ball_y_q   <= '0;
            ball_vld_q <= 1'b0;
            hit_flag_q <= 1'b0;
            shot_q     <= 1'b0;
            hit_q      <= 1'b0;
            lines_q    <= '0;
        end else begin
            hsync_q    <= hsync;
            vsync_q    <= vsync;
            trig_q     <= trigger;
            hs_rise_q  <= hsync & ~hsync_q;
            vs_rise_q  <= vsync & ~vsync_q;
            tr_rise_q  <= trigger & ~trig_q;
            x_q        <= x_d;
            y_q        <= y_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            found_q    <= found_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            ball_vld_q <= ball_vld_d;
            case (state_q)
                IDLE: begin
                    if (tr_rise_q) state_q <= ARMED;
                end
                ARMED: begin
                    if (vs_rise_q) begin
                        hit_flag_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (vs_rise_q) begin
                        state_q <= REPORT;
                        lines_q <= LCW'(SHOT_LINES);
                        shot_q  <= 1'b1;
                        hit_q   <= hit_flag_q;
                    end else if (pix && win) begin
                        hit_flag_q <= 1'b1;
                    end
                end
                REPORT: begin
                    // Only line starts count; a frame start inside the pulse is just another line.
                    if (hs_rise_q) begin
                        lines_q <= lines_dec;
                        if (lines_dec == '0) begin
                            state_q <= IDLE;
                            shot_q  <= 1'b0;
                            hit_q   <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign shot_out = shot_q;
    assign hit_out  = hit_q;
    assign ball_x   = ball_x_q;
    assign ball_y   = ball_y_q;
    assign ball_vld = ball_vld_q;

endmodule
